// File: rtl/sram_1p_march_bist.sv
// sram_1p_march_bist: March C- BIST engine driving a single-port SRAM BIST port
module sram_1p_march_bist #(
  parameter int P_DATA_WIDTH = 16,
  parameter int P_ADDR_WIDTH = 12,
  parameter int P_STOP_ON_FAIL = 0
) (
  input  logic                    A_BIST_CLK,
  input  logic                    A_BIST_RST,
  input  logic                    START,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    FAIL,
  output logic [15:0]             FAIL_CNT,
  output logic [P_ADDR_WIDTH-1:0] FAIL_ADDR,
  output logic [P_DATA_WIDTH-1:0] FAIL_EXP,
  output logic [P_DATA_WIDTH-1:0] FAIL_GOT,
  output logic                    A_BIST_EN,
  output logic                    A_BIST_MEN,
  output logic                    A_BIST_WEN,
  output logic                    A_BIST_REN,
  output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
  output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
  output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
  input  logic [P_DATA_WIDTH-1:0] A_DOUT
);
  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_M0    = 4'd1;
  localparam logic [3:0] S_M1    = 4'd2;
  localparam logic [3:0] S_M2    = 4'd3;
  localparam logic [3:0] S_M3    = 4'd4;
  localparam logic [3:0] S_M4    = 4'd5;
  localparam logic [3:0] S_M5    = 4'd6;
  localparam logic [3:0] S_DRAIN = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;
  localparam logic [P_ADDR_WIDTH-1:0] A_ONE = P_ADDR_WIDTH'(1);
  logic [3:0] st_q, st_d;
  logic [P_ADDR_WIDTH-1:0] addr_q, addr_d, ao_q, ao_d, ca_q, fa_q;
  logic ph_q, ph_d, busy_q, busy_d, done_q, done_d;
  logic men_q, men_d, wen_q, wen_d, ren_q, ren_d, dat_q, dat_d;
  logic cv_q, fail_q;
  logic [P_DATA_WIDTH-1:0] ce_q, fe_q, fg_q;
  logic [15:0] cnt_q;
  logic march, two, down, last_a, mis, stop, start, op_d, rd_d;
  // Sequencer state (st/addr/ph) names the op to present next; port pins are registered from it.
  always_comb begin
    march  = st_q >= S_M0 && st_q <= S_M5;
    two    = st_q >= S_M1 && st_q <= S_M4;
    down   = st_q == S_M3 || st_q == S_M4;
    last_a = down ? addr_q == '0 : &addr_q;
    mis    = cv_q && (A_DOUT != ce_q);
    stop   = P_STOP_ON_FAIL != 0 && mis;
    start  = START && (st_q == S_IDLE || st_q == S_DONE);
    st_d   = st_q;
    addr_d = addr_q;
    ph_d   = ph_q;
    if (start) begin
      st_d   = S_M0;
      addr_d = '0;
      ph_d   = 1'b0;
    end else if (stop) begin
      st_d = S_DONE;
    end else if (march) begin
      if (two && !ph_q) begin
        ph_d = 1'b1;
      end else begin
        ph_d = 1'b0;
        if (last_a) begin
          st_d   = st_q + 4'd1;
          addr_d = (st_q == S_M2 || st_q == S_M3) ? '1 : '0;
        end else begin
          addr_d = down ? addr_q - A_ONE : addr_q + A_ONE;
        end
      end
    end else if (st_q == S_DRAIN) begin
      st_d = S_DONE;
    end
    op_d   = st_d >= S_M0 && st_d <= S_M5;
    rd_d   = op_d && st_d != S_M0 && !ph_d;
    men_d  = op_d;
    wen_d  = op_d && !rd_d;
    ren_d  = rd_d;
    ao_d   = op_d ? addr_d : '0;
    dat_d  = op_d && (ph_d ? (st_d == S_M1 || st_d == S_M3) : (st_d == S_M2 || st_d == S_M4));
    busy_d = st_d >= S_M0 && st_d <= S_DRAIN;
    done_d = st_d == S_DONE;
  end
  always_ff @(posedge A_BIST_CLK) begin
    if (A_BIST_RST) begin
      st_q   <= S_IDLE;
      addr_q <= '0;
      ph_q   <= 1'b0;
      ao_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      men_q  <= 1'b0;
      wen_q  <= 1'b0;
      ren_q  <= 1'b0;
      dat_q  <= 1'b0;
      cv_q   <= 1'b0;
      ce_q   <= '0;
      ca_q   <= '0;
      fail_q <= 1'b0;
      cnt_q  <= '0;
      fa_q   <= '0;
      fe_q   <= '0;
      fg_q   <= '0;
    end else begin
      st_q   <= st_d;
      addr_q <= addr_d;
      ph_q   <= ph_d;
      ao_q   <= ao_d;
      busy_q <= busy_d;
      done_q <= done_d;
      men_q  <= men_d;
      wen_q  <= wen_d;
      ren_q  <= ren_d;
      dat_q  <= dat_d;
      cv_q   <= ren_q && !stop;
      ce_q   <= {P_DATA_WIDTH{dat_q}};
      ca_q   <= ao_q;
      if (start) begin
        fail_q <= 1'b0;
        cnt_q  <= '0;
        fa_q   <= '0;
        fe_q   <= '0;
        fg_q   <= '0;
      end else if (mis) begin
        fail_q <= 1'b1;
        cnt_q  <= cnt_q + 16'(cnt_q != 16'hFFFF);
        if (!fail_q) begin
          fa_q <= ca_q;
          fe_q <= ce_q;
          fg_q <= A_DOUT;
        end
      end
    end
  end
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign FAIL        = fail_q;
  assign FAIL_CNT    = cnt_q;
  assign FAIL_ADDR   = fa_q;
  assign FAIL_EXP    = fe_q;
  assign FAIL_GOT    = fg_q;
  assign A_BIST_EN   = busy_q;
  assign A_BIST_MEN  = men_q;
  assign A_BIST_WEN  = wen_q;
  assign A_BIST_REN  = ren_q;
  assign A_BIST_ADDR = ao_q;
  assign A_BIST_DIN  = {P_DATA_WIDTH{dat_q}};
  assign A_BIST_BM   = {P_DATA_WIDTH{men_q}};
endmodule

// File: tb/tb_sram_1p_march_bist.sv
// tb_sram_1p_march_bist: table-driven check of the March C- BIST against SRAM models (N=8, N=8 stop-on-fail, N=4096)
module tb_sram_1p_march_bist;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic [2:0] start;
  logic fault;
  logic o_busy[3], o_done[3], o_fail[3], o_en[3], o_men[3], o_wen[3], o_ren[3];
  logic [15:0] o_cnt[3], o_fe[3], o_fg[3], o_din[3], o_bm[3];
  logic [11:0] o_fa[3], o_addr[3];
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int AW = g == 2 ? 12 : 3;
    logic [AW-1:0] fa, ad;
    logic [15:0] cnt, fe, fg, di, bm, dout;
    logic bz, dn, fl, en, men, wen, ren;
    logic [15:0] mem [2**AW];
    sram_1p_march_bist #(.P_DATA_WIDTH(16), .P_ADDR_WIDTH(AW), .P_STOP_ON_FAIL(g == 1 ? 1 : 0)) dut (
      .A_BIST_CLK(clk), .A_BIST_RST(rst), .START(start[g]), .BUSY(bz), .DONE(dn), .FAIL(fl),
      .FAIL_CNT(cnt), .FAIL_ADDR(fa), .FAIL_EXP(fe), .FAIL_GOT(fg), .A_BIST_EN(en), .A_BIST_MEN(men),
      .A_BIST_WEN(wen), .A_BIST_REN(ren), .A_BIST_ADDR(ad), .A_BIST_DIN(di), .A_BIST_BM(bm), .A_DOUT(dout)
    );
    // Macro model; the injected fault is bit 5 of address 3 stuck at 1 (N=8 instances only)
    always @(posedge clk) begin
      if (en && men && wen) mem[ad] <= (mem[ad] & ~bm) | (di & bm);
      if (en && men && ren) dout <= mem[ad] | ((fault && g != 2 && ad == AW'(3)) ? 16'h0020 : 16'h0000);
    end
    assign o_busy[g] = bz;
    assign o_done[g] = dn;
    assign o_fail[g] = fl;
    assign o_en[g]   = en;
    assign o_men[g]  = men;
    assign o_wen[g]  = wen;
    assign o_ren[g]  = ren;
    assign o_cnt[g]  = cnt;
    assign o_fe[g]   = fe;
    assign o_fg[g]   = fg;
    assign o_din[g]  = di;
    assign o_bm[g]   = bm;
    assign o_fa[g]   = 12'(fa);
    assign o_addr[g] = 12'(ad);
  end
  typedef struct packed {logic w; logic [11:0] a; logic d;} op_t;
  typedef struct {int g; bit flt; int de; int pulse; bit fl; int cnt; int fa; logic [15:0] fe; logic [15:0] fg;} vec_t;
  op_t eq[$];
  int nvec = 0;
  int nerr = 0;
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      if (nerr <= 30) $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask
  task automatic build(input int n);
    bit e_dn[6] = '{0, 0, 0, 1, 1, 0};
    bit e_r[6]  = '{0, 1, 1, 1, 1, 1};
    bit e_rv[6] = '{0, 0, 1, 0, 1, 0};
    bit e_w[6]  = '{1, 1, 1, 1, 1, 0};
    bit e_wv[6] = '{0, 1, 0, 1, 0, 0};
    eq.delete();
    for (int e = 0; e < 6; e++)
      for (int i = 0; i < n; i++) begin
        int a;
        a = e_dn[e] ? n - 1 - i : i;
        if (e_r[e]) eq.push_back('{1'b0, 12'(a), e_rv[e]});
        if (e_w[e]) eq.push_back('{1'b1, 12'(a), e_wv[e]});
      end
  endtask
  task automatic chk_zero(input int g, input string nm);
    chk({nm, "_ctl"}, 128'({o_done[g], o_busy[g], o_fail[g], o_en[g], o_men[g], o_wen[g], o_ren[g], o_cnt[g], o_addr[g]}), 128'(0));
    chk({nm, "_data"}, 128'({o_fa[g], o_fe[g], o_fg[g], o_din[g], o_bm[g]}), 128'(0));
  endtask
  task automatic do_reset(input int g);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_zero(g, "reset");
  endtask
  task automatic kick(input int g);
    @(negedge clk);
    start[g] = 1'b1;
    @(posedge clk);
    #1;
    start[g] = 1'b0;
  endtask
  task automatic run(input vec_t v, input bit do_rst);
    int g, n;
    logic [49:0] act, exp;
    op_t op;
    g = v.g;
    n = g == 2 ? 4096 : 8;
    fault = v.flt;
    build(n);
    if (do_rst) do_reset(g);
    kick(g);
    for (int e = 0; e <= v.de; e++) begin
      if (e > 0) begin
        @(posedge clk);
        #1;
      end
      if (e < v.de && e < 10 * n) begin
        op = eq[e];
        act = {o_done[g], o_busy[g], o_en[g], o_men[g], o_wen[g], o_ren[g], o_addr[g], o_din[g] & {16{op.w}}, o_bm[g]};
        exp = {1'b0, 1'b1, 1'b1, 1'b1, op.w, !op.w, op.a, {16{op.w & op.d}}, 16'hFFFF};
      end else begin
        act = {o_done[g], o_busy[g], o_en[g], o_men[g], o_wen[g], o_ren[g], o_addr[g], o_din[g], o_bm[g]};
        exp = e < v.de ? {2'b01, 1'b1, 47'd0} : {2'b10, 48'd0};
      end
      chk($sformatf("cyc g%0d e%0d", g, e), 128'(act), 128'(exp));
      if (e == v.pulse - 1) start[g] = 1'b1;
      if (e == v.pulse) start[g] = 1'b0;
    end
    chk("fail", 128'(o_fail[g]), 128'(v.fl));
    chk("fail_cnt", 128'(o_cnt[g]), 128'(v.cnt));
    chk("fail_addr", 128'(o_fa[g]), 128'(v.fa));
    chk("fail_exp", 128'(o_fe[g]), 128'(v.fe));
    chk("fail_got", 128'(o_fg[g]), 128'(v.fg));
    @(posedge clk);
    #1;
    chk("done_hold", 128'({o_done[g], o_busy[g], o_en[g]}), 128'(3'b100));
  endtask
  initial begin
    vec_t vt[6];
    vt[0] = '{0, 1'b0, 81,    -1, 1'b0, 0, 0, 16'h0000, 16'h0000};
    vt[1] = '{0, 1'b1, 81,    -1, 1'b1, 3, 3, 16'h0000, 16'h0020};
    vt[2] = '{1, 1'b1, 16,    -1, 1'b1, 1, 3, 16'h0000, 16'h0020};
    vt[3] = '{1, 1'b0, 81,    -1, 1'b0, 0, 0, 16'h0000, 16'h0000};
    vt[4] = '{0, 1'b0, 81,    20, 1'b0, 0, 0, 16'h0000, 16'h0000};
    vt[5] = '{2, 1'b0, 40961, -1, 1'b0, 0, 0, 16'h0000, 16'h0000};
    rst = 1'b1;
    start = '0;
    fault = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) run(vt[i], 1'b1);
    // START while in DONE after a failing run restarts and clears results on that edge
    run(vt[1], 1'b1);
    fault = 1'b0;
    kick(0);
    chk("restart_state", 128'({o_done[0], o_busy[0], o_fail[0], o_cnt[0]}), 128'({1'b0, 1'b1, 1'b0, 16'd0}));
    chk("restart_diag", 128'({o_fa[0], o_fe[0], o_fg[0]}), 128'(0));
    chk("restart_op1", 128'({o_men[0], o_wen[0], o_ren[0], o_addr[0]}), 128'({3'b110, 12'd0}));
    // Reset in the middle of M3 with a fault already logged
    do_reset(0);
    fault = 1'b1;
    kick(0);
    repeat (45) @(posedge clk);
    #1;
    chk("midm3_pre", 128'({o_busy[0], o_fail[0], o_cnt[0]}), 128'({1'b1, 1'b1, 16'd1}));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_zero(0, "midm3_rst");
    run(vt[0], 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
